// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 4-digit multiplexed display scheduler.
package seg_scan_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low anode with only the selected digit pulled low.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Value handshake plus the nibble/anode outputs feeding the shared segment decoder.
interface seg_scan_scheduler_if;

    logic [15:0] val_data;
    logic        val_valid;
    logic        val_ready;
    logic [3:0]  digit_en;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        blank;
    logic        frame_start;

    modport master (
        output val_data, val_valid, digit_en,
        input  val_ready, nibble, an, blank, frame_start
    );

    modport slave (
        input  val_data, val_valid, digit_en,
        output val_ready, nibble, an, blank, frame_start
    );

endinterface

// File: rtl/seg_scan_slot_timer.sv
// Slot counter and digit index; exposes next-cycle values so the parent can
// register outputs that line up with the counter of the same cycle.
module seg_scan_slot_timer #(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    output logic [DIV_W-1:0] o_cnt_next,
    output logic [1:0]       o_idx,
    output logic [1:0]       o_idx_next,
    output logic             o_wrap,
    output logic             o_frame_start
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_frame_start;

    always_comb begin
        o_wrap     = (r_cnt == LAST);
        o_cnt_next = o_wrap ? '0 : r_cnt + 1'b1;
        o_idx_next = o_wrap ? r_idx + 2'd1 : r_idx;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_idx         <= 2'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= o_cnt_next;
            r_idx         <= o_idx_next;
            // High during the first cycle of slot 0, i.e. after the 3->0 wrap.
            r_frame_start <= o_wrap && (r_idx == 2'd3);
        end
    end

    assign o_idx         = r_idx;
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/seg_scan_scheduler.sv
// Digit scan FSM with anti-ghost blanking and frame-synchronous value update.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg_scan_scheduler
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int DIV_W     = 16
) (
    input  logic                  clk_in,
    input  logic                  rst,
    seg_scan_scheduler_if.slave   bus
);

    localparam logic [DIV_W-1:0] BLANK_END   = DIV_W'(BLANK_CYC);
    localparam scan_state_t      RESET_STATE = (BLANK_CYC == 0) ? DRIVE : BLANK;

    logic [DIV_W-1:0] w_cnt_next;
    logic [1:0]       w_idx, w_idx_next;
    logic             w_wrap, w_frame_start, w_frame_edge;
    scan_state_t      r_state, w_state_next;
    logic [15:0]      r_shadow, r_pending, w_view;
    logic             r_pend_full, w_accept, w_load;
    logic             r_slot_en, r_en_valid, w_en_next, w_show, w_drive_next;
    logic [3:0]       r_an, r_nibble;
    logic             r_blank;

    seg_scan_slot_timer #(
        .SCAN_DIV (SCAN_DIV),
        .DIV_W    (DIV_W)
    ) u_timer (
        .clk_in        (clk_in),
        .rst           (rst),
        .o_cnt_next    (w_cnt_next),
        .o_idx         (w_idx),
        .o_idx_next    (w_idx_next),
        .o_wrap        (w_wrap),
        .o_frame_start (w_frame_start)
    );

    assign w_frame_edge = w_wrap && (w_idx == 2'd3);
    assign w_accept     = bus.val_valid && !r_pend_full;
    assign w_load       = w_frame_start && r_pend_full;

    // Around the frame boundary the pending value is already the one on display,
    // so even a zero-length blank phase never shows a stale digit.
    assign w_view = ((w_frame_edge || w_frame_start) && r_pend_full) ? r_pending : r_shadow;

    // Enable is latched on entry to each slot; the slot running out of reset samples on its first edge.
    assign w_en_next = w_wrap ? bus.digit_en[w_idx_next]
                              : (r_en_valid ? r_slot_en : bus.digit_en[w_idx]);

`ifdef LEADING_ZERO_BLANK_EN
    genvar gi;
    logic [NUM_DIGITS-1:0] w_upper_nz;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        if (gi == 0) begin : g_first
            assign w_upper_nz[gi] = 1'b1;
        end else begin : g_rest
            assign w_upper_nz[gi] = |(w_view >> (4 * gi));
        end
    end
    assign w_show = w_en_next && w_upper_nz[w_idx_next];
`else
    assign w_show = w_en_next;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BLANK:   if (w_cnt_next == BLANK_END) w_state_next = DRIVE;
            DRIVE:   if (w_wrap && (BLANK_CYC != 0)) w_state_next = BLANK;
            default: w_state_next = RESET_STATE;
        endcase
        w_drive_next = (w_state_next == DRIVE) && w_show;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) r_state <= RESET_STATE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_an        <= AN_OFF;
            r_blank     <= 1'b1;
            r_nibble    <= 4'd0;
            r_shadow    <= 16'd0;
            r_pending   <= 16'd0;
            r_pend_full <= 1'b0;
            r_slot_en   <= 1'b0;
            r_en_valid  <= 1'b0;
        end else begin
            r_an       <= w_drive_next ? anode_for(w_idx_next) : AN_OFF;
            r_blank    <= !w_drive_next;
            r_nibble   <= w_view[4*w_idx_next +: 4];
            r_slot_en  <= w_en_next;
            r_en_valid <= 1'b1;
            if (w_load) begin
                r_shadow    <= r_pending;
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pending   <= bus.val_data;
                r_pend_full <= 1'b1;
            end
        end
    end

    assign bus.val_ready   = !r_pend_full;
    assign bus.an          = r_an;
    assign bus.blank       = r_blank;
    assign bus.nibble      = r_nibble;
    assign bus.frame_start = w_frame_start;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with a time-indexed reference model and a
// one-deep scoreboard queue of accepted display values.
module tb_seg_scan_scheduler;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * SD;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;

    seg_scan_scheduler_if bus ();

    seg_scan_scheduler #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC),
        .DIV_W     (16)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int          checks   = 0;
    int          failures = 0;
    int          t        = 0;
    int          pushes   = 0;
    logic [15:0] m_shadow = 16'd0;
    logic [3:0]  en_lat   = 4'hF;
    logic [15:0] sb_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    function automatic logic digit_shown(input int k);
        logic s;
        s = en_lat[k];
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && (m_shadow >> (4 * k)) == 16'd0) s = 1'b0;
`endif
        return s;
    endfunction

    task automatic compare();
        int         pos;
        int         slot;
        logic       drive;
        logic [3:0] exp_an;
        pos    = t % SD;
        slot   = (t / SD) % 4;
        drive  = (pos >= BC) && digit_shown(slot);
        exp_an = drive ? ~(4'b0001 << slot) : 4'b1111;
        chk("an", 16'(bus.an), 16'(exp_an));
        chk("blank", 16'(bus.blank), 16'(!drive));
        chk("frame_start", 16'(bus.frame_start), 16'(t > 0 && (t % FRAME) == 0));
        chk("val_ready", 16'(bus.val_ready), 16'(sb_q.size() == 0));
        if (drive) chk("nibble", 16'(bus.nibble), 16'(m_shadow[4*slot +: 4]));
    endtask

    task automatic tick();
        bit fs;
        fs = (t > 0 && (t % FRAME) == 0);
        @(posedge clk_in);
        if (fs && sb_q.size() != 0) begin
            m_shadow = sb_q.pop_front();
        end else if (bus.val_valid && sb_q.size() == 0) begin
            sb_q.push_back(bus.val_data);
            pushes++;
        end
        if (((t + 1) % SD) == 0) en_lat = bus.digit_en;
        t++;
        @(negedge clk_in);
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_an", 16'(bus.an), 16'h000F);
        chk("rst_blank", 16'(bus.blank), 16'h0001);
        chk("rst_ready", 16'(bus.val_ready), 16'h0001);
        chk("rst_frame_start", 16'(bus.frame_start), 16'h0000);
        chk("rst_nibble", 16'(bus.nibble), 16'h0000);
        @(posedge clk_in);
        @(negedge clk_in);
        rst      = 1'b0;
        t        = 0;
        m_shadow = 16'd0;
        en_lat   = bus.digit_en;
        sb_q.delete();
        compare();
    endtask

    task automatic bound_ok(input string tag, input int guard, input int limit);
        checks++;
        assert (guard < limit) else begin
            failures++;
            $error("FAIL %s observed=timeout(%0d cycles) expected=event", tag, guard);
        end
    endtask

    initial begin
        int guard;
        bus.val_valid = 1'b0;
        bus.val_data  = 16'd0;
        bus.digit_en  = 4'hF;

        // Free-running scan after reset: blank/drive pattern and frame pulses.
        do_reset();
        run(70);

        // 0x1234 accepted mid-frame, 0xABCD held while pending is full.
        bus.val_data  = 16'h1234;
        bus.val_valid = 1'b1;
        tick();
        bus.val_data = 16'hABCD;
        guard = 0;
        while (pushes < 2 && guard < 100) begin
            tick();
            guard++;
        end
        bound_ok("abcd_accept", guard, 100);
        bus.val_valid = 1'b0;
        run(70);

        // Digits 1 and 3 disabled.
        run(3);
        bus.digit_en = 4'b0101;
        run(80);
        bus.digit_en = 4'hF;

        // Values with leading zeros.
        bus.val_data  = 16'h0050;
        bus.val_valid = 1'b1;
        tick();
        bus.val_valid = 1'b0;
        run(70);
        bus.val_data  = 16'h0000;
        bus.val_valid = 1'b1;
        tick();
        bus.val_valid = 1'b0;
        run(70);

        // Reset during DRIVE of slot 2 while a value is pending.
        guard = 0;
        while ((t % FRAME) != 5 && guard < 100) begin
            tick();
            guard++;
        end
        bound_ok("align_frame", guard, 100);
        bus.val_data  = 16'h7777;
        bus.val_valid = 1'b1;
        tick();
        bus.val_valid = 1'b0;
        guard = 0;
        while (!(sb_q.size() != 0 && (t % FRAME) == 2 * SD + 4) && guard < 100) begin
            tick();
            guard++;
        end
        bound_ok("reach_slot2", guard, 100);
        do_reset();
        run(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
